matrix_arith_unit: RTL and testbench
====================================

Name: matrix_arith_unit

Overview:
Sequential, parametrised successor to the combinational matrix adder. It latches two row-major matrices packed in one input bus, and an opcode selecting add, subtract, scalar multiply or transpose. It computes one element per clock and reports completion with a start/done handshake. It sits between the matrix input/storage logic and the display/output stage of the calculator datapath.

Parameters:
DW, 8, element width in bits; all arithmetic is modulo 2^DW.
MAX_DIM, 5, maximum rows/columns per matrix.
DIMW, 3, width of the dimension inputs; must satisfy 2^DIMW > MAX_DIM.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request pulse; accepted only in IDLE.
op  input  2  00 add A+B, 01 subtract A-B, 10 scalar multiply A*scalar, 11 transpose A.
m  input  DIMW  row count of A (and of B).
n  input  DIMW  column count of A (and of B).
scalar  input  DW  multiplier used when op=10.
matrices_in  input  2*MAX_DIM*MAX_DIM*DW  A in the low half, B in the high half; element (r,c) at offset (r*MAX_DIM+c)*DW.
matrices_out  output  2*MAX_DIM*MAX_DIM*DW  result C in the low half with the same layout; high half always 0.
res_m  output  DIMW  row count of C.
res_n  output  DIMW  column count of C.
busy  output  1  high while a request is being processed.
done  output  1  one-cycle pulse at the end of every accepted request.
valid  output  1  C is a valid result; held until the next accepted start.
error  output  1  last request had illegal dimensions; held until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; internal latches and row/column counters cleared.
- Reset mid-operation aborts the request. No done is produced.
- States: IDLE, RUN, FIN, ERR.
- IDLE to RUN, on start=1:
  - m and n must both be in the range 1..MAX_DIM.
  - Latch op, m, n, scalar and matrices_in into internal registers.
  - Clear matrices_out, valid and error.
  - Set row=0, col=0.
- IDLE to ERR, on start=1 with m=0, n=0, m>MAX_DIM or n>MAX_DIM:
  - Clear matrices_out and valid.
- RUN, each cycle:
  - Write element (row,col) of C.
  - Advance col; on col=n-1, set col=0 and advance row.
  - After element (m-1,n-1) is written, go to FIN.
- FIN: done=1 and valid=1; res_m/res_n driven; go to IDLE.
- ERR: done=1, error=1, valid=0, res_m=res_n=0; go to IDLE.
- busy=1 in RUN, FIN and ERR; busy=0 in IDLE.
- Latency: start sampled at edge k → done high during the cycle after edge k+m*n+1. An error request gives done after edge k+1.
- Throughput: a new start may be accepted in the cycle done is high? No. State is FIN/ERR then, so start is ignored. It is accepted from the next IDLE cycle.
- start while busy=1 is ignored with no side effects.
- Inputs are used only from the latch. Changes to inputs during RUN do not affect the result.
- Arithmetic:
  - add: C(r,c) = A(r,c)+B(r,c), truncated to DW bits.
  - subtract: C(r,c) = A(r,c)-B(r,c), two's-complement wrap.
  - scalar multiply: C(r,c) = low DW bits of A(r,c)*scalar (unsigned).
  - transpose: C(c,r) = A(r,c); res_m=n, res_n=m.
  - For ops 00–10: res_m=m, res_n=n.
- Elements of C outside res_m x res_n are 0.
- Elements of A/B outside m x n are never read.
- matrices_out, res_m, res_n, valid and error hold their values in IDLE until the next accepted start or reset.

Test Plan:
- Add: m=2, n=3, A=[1 2 3;3 4 5], B=[3 3 3;2 2 2], start pulse → busy for 8 cycles. done after edge k+7, valid=1, C=[4 5 6;5 6 7], res 2x3, all other bytes 0.
- Subtract wrap: same A/B with op=01 → C=[254 255 0;1 2 3]. Then a 5x5 add of A=all 200 and B=all 100 → all 44, done after edge k+26.
- Scalar multiply: m=n=3, A(1,1)=3, A(2,2)=100, other elements 1, scalar=3 → C(1,1)=9, C(2,2)=44 (300 mod 256), others 3.
- Transpose: m=2, n=3, A=[1 2 3;4 5 6] → res_m=3, res_n=2, C=[1 4;2 5;3 6]. Layout check: C(1,0)=2 at byte 5.
- Illegal dimensions: m=0,n=3, and separately m=6,n=2 → done one cycle after start, error=1, valid=0, matrices_out all 0. A following legal start clears error.
- Robustness:
  - start pulsed again mid-RUN is ignored, and the result matches a single request.
  - matrices_in changed mid-RUN does not affect C.
  - reset=0 mid-RUN immediately zeroes all outputs, with no done.
  - A fresh request after reset produces the correct result.

Source files
------------

// File: rtl/matrix_arith_unit.sv
// Sequential matrix arithmetic unit: add, subtract, scalar multiply or transpose,
// one element per clock, with a start/busy/done handshake.
module matrix_arith_unit #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_DIM = 5,
  parameter int unsigned DIMW    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    op,
  input  logic [DIMW-1:0]               m,
  input  logic [DIMW-1:0]               n,
  input  logic [DW-1:0]                 scalar,
  input  logic [2*MAX_DIM*MAX_DIM*DW-1:0] matrices_in,
  output logic [2*MAX_DIM*MAX_DIM*DW-1:0] matrices_out,
  output logic [DIMW-1:0]               res_m,
  output logic [DIMW-1:0]               res_n,
  output logic                          busy,
  output logic                          done,
  output logic                          valid,
  output logic                          error
);

  localparam int unsigned HW   = MAX_DIM * MAX_DIM * DW;
  localparam int unsigned IDXW = $clog2(MAX_DIM * MAX_DIM);

  typedef enum logic [1:0] {IDLE, RUN, FIN, ERR} state_t;

  state_t            state, next_state;
  logic [1:0]        op_q;
  logic [DIMW-1:0]   m_q, n_q, row, col;
  logic [DW-1:0]     scal_q;
  logic [HW-1:0]     a_q, b_q, c_q;

  logic              accept, dims_bad, last;
  logic [IDXW-1:0]   src_idx, dst_idx;
  logic [DW-1:0]     a_el, b_el, elem;

  assign matrices_out = {HW'(0), c_q};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state; busy also blocks the done cycle so a start there is ignored
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    dims_bad   = (m == '0) || (n == '0) || (m > DIMW'(MAX_DIM)) || (n > DIMW'(MAX_DIM));
    last       = (row == m_q - DIMW'(1)) && (col == n_q - DIMW'(1));
    case (state)
      IDLE: begin
        if (start && !busy) begin
          accept     = 1'b1;
          next_state = dims_bad ? ERR : RUN;
        end
      end
      RUN:     if (last) next_state = FIN;
      FIN:     next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Element datapath; transpose redirects the write to (col,row)
  always_comb begin
    src_idx = IDXW'(row) * IDXW'(MAX_DIM) + IDXW'(col);
    dst_idx = (op_q == 2'b11) ? IDXW'(col) * IDXW'(MAX_DIM) + IDXW'(row) : src_idx;
    a_el    = a_q[src_idx*DW +: DW];
    b_el    = b_q[src_idx*DW +: DW];
    case (op_q)
      2'b00:   elem = a_el + b_el;
      2'b01:   elem = a_el - b_el;
      2'b10:   elem = a_el * scal_q;
      default: elem = a_el;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      m_q    <= '0;
      n_q    <= '0;
      scal_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      row    <= '0;
      col    <= '0;
      res_m  <= '0;
      res_n  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      valid  <= 1'b0;
      error  <= 1'b0;
    end else begin
      busy <= (state != IDLE) || (next_state != IDLE);
      done <= 1'b0;
      if (accept) begin
        c_q   <= '0;
        valid <= 1'b0;
        error <= 1'b0;
        res_m <= '0;
        res_n <= '0;
        row   <= '0;
        col   <= '0;
        if (!dims_bad) begin
          op_q   <= op;
          m_q    <= m;
          n_q    <= n;
          scal_q <= scalar;
          a_q    <= matrices_in[HW-1:0];
          b_q    <= matrices_in[2*HW-1:HW];
        end
      end
      if (state == RUN) begin
        c_q[dst_idx*DW +: DW] <= elem;
        if (col == n_q - DIMW'(1)) begin
          col <= '0;
          row <= row + DIMW'(1);
        end else begin
          col <= col + DIMW'(1);
        end
      end
      if (state == FIN) begin
        done  <= 1'b1;
        valid <= 1'b1;
        res_m <= (op_q == 2'b11) ? n_q : m_q;
        res_n <= (op_q == 2'b11) ? m_q : n_q;
      end
      if (state == ERR) begin
        done  <= 1'b1;
        error <= 1'b1;
        valid <= 1'b0;
        res_m <= '0;
        res_n <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_arith_unit.sv
// Directed, table-driven bench for matrix_arith_unit with hand-computed results
// plus sequences for mid-run start, start in the done cycle and mid-run reset.
module tb_matrix_arith_unit;

  localparam int DW   = 8;
  localparam int MD   = 5;
  localparam int DIMW = 3;
  localparam int HW   = MD * MD * DW;
  localparam int OW   = 2 * HW;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = '0;
  logic [DIMW-1:0] m = '0;
  logic [DIMW-1:0] n = '0;
  logic [DW-1:0]   scalar = '0;
  logic [OW-1:0]   matrices_in = '0;
  logic [OW-1:0]   matrices_out;
  logic [DIMW-1:0] res_m, res_n;
  logic            busy, done, valid, error;

  matrix_arith_unit #(.DW(DW), .MAX_DIM(MD), .DIMW(DIMW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .m(m), .n(n),
    .scalar(scalar), .matrices_in(matrices_in), .matrices_out(matrices_out),
    .res_m(res_m), .res_n(res_n), .busy(busy), .done(done), .valid(valid),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      op;
    logic [DIMW-1:0] m, n;
    logic [DW-1:0]   scalar;
    logic [HW-1:0]   a, b, c;
    logic [DIMW-1:0] rm, rn;
    logic            err;
    int              lat;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] mat6(input int nr, input int nc, input int e0, input int e1,
                                          input int e2, input int e3, input int e4, input int e5);
    int e[6];
    logic [HW-1:0] v;
    e = '{e0, e1, e2, e3, e4, e5};
    v = '0;
    for (int i = 0; i < nr * nc; i++) v[((i / nc) * MD + (i % nc)) * DW +: DW] = DW'(e[i]);
    return v;
  endfunction

  function automatic logic [HW-1:0] fill(input int nr, input int nc, input int val);
    logic [HW-1:0] v;
    v = '0;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++) v[(r * MD + c) * DW +: DW] = DW'(val);
    return v;
  endfunction

  function automatic logic [HW-1:0] setel(input logic [HW-1:0] v, input int r, input int c, input int val);
    logic [HW-1:0] t;
    t = v;
    t[(r * MD + c) * DW +: DW] = DW'(val);
    return t;
  endfunction

  // Drive one request; unused elements carry junk and all inputs are scrambled after the accept edge
  task automatic issue(input vec_t v);
    logic [HW-1:0] ga, gb;
    ga = v.a;
    gb = v.b;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        if (r >= int'(v.m) || c >= int'(v.n)) begin
          ga[(r * MD + c) * DW +: DW] = 8'hEE;
          gb[(r * MD + c) * DW +: DW] = 8'hEE;
        end
    @(negedge clk);
    op = v.op; m = v.m; n = v.n; scalar = v.scalar;
    matrices_in = {gb, ga};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    matrices_in = ~matrices_in;
    op = ~op;
    m = 3'd5;
    n = 3'd5;
    scalar = ~scalar;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int done_seen;

    vecs[0] = '{2'b00, 3'd2, 3'd3, 8'd0, mat6(2,3,1,2,3,3,4,5), mat6(2,3,3,3,3,2,2,2),
                mat6(2,3,4,5,6,5,6,7), 3'd2, 3'd3, 1'b0, 7};
    vecs[1] = '{2'b01, 3'd2, 3'd3, 8'd0, mat6(2,3,1,2,3,3,4,5), mat6(2,3,3,3,3,2,2,2),
                mat6(2,3,254,255,0,1,2,3), 3'd2, 3'd3, 1'b0, 7};
    vecs[2] = '{2'b00, 3'd5, 3'd5, 8'd0, fill(5,5,200), fill(5,5,100), fill(5,5,44),
                3'd5, 3'd5, 1'b0, 26};
    vecs[3] = '{2'b10, 3'd3, 3'd3, 8'd3, setel(setel(fill(3,3,1),1,1,3),2,2,100), fill(3,3,9),
                setel(setel(fill(3,3,3),1,1,9),2,2,44), 3'd3, 3'd3, 1'b0, 10};
    vecs[4] = '{2'b11, 3'd2, 3'd3, 8'd0, mat6(2,3,1,2,3,4,5,6), fill(2,3,77),
                mat6(3,2,1,4,2,5,3,6), 3'd3, 3'd2, 1'b0, 7};
    vecs[5] = '{2'b00, 3'd0, 3'd3, 8'd0, fill(2,3,5), fill(2,3,6), '0, 3'd0, 3'd0, 1'b1, 1};
    vecs[6] = '{2'b00, 3'd6, 3'd2, 8'd0, fill(5,2,5), fill(5,2,6), '0, 3'd0, 3'd0, 1'b1, 1};
    vecs[7] = '{2'b00, 3'd1, 3'd1, 8'd0, mat6(1,1,7,0,0,0,0,0), mat6(1,1,250,0,0,0,0,0),
                mat6(1,1,1,0,0,0,0,0), 3'd1, 3'd1, 1'b0, 2};
    vecs[8] = '{2'b11, 3'd1, 3'd5, 8'd0, mat6(1,5,10,20,30,40,50,0), fill(1,5,1),
                mat6(5,1,10,20,30,40,50,0), 3'd5, 3'd1, 1'b0, 6};
    vecs[9] = '{2'b10, 3'd2, 3'd2, 8'd16, mat6(2,2,16,17,255,128,0,0), fill(2,2,3),
                mat6(2,2,0,16,240,0,0,0), 3'd2, 3'd2, 1'b0, 5};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_matrices_out", matrices_out, '0);
    chk("reset_flags", OW'({busy, done, valid, error, res_m, res_n}), '0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i]);
      chk($sformatf("v%0d_busy_after_accept", i), OW'(busy), OW'(1));
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), OW'(lat), OW'(vecs[i].lat));
      chk($sformatf("v%0d_error", i), OW'(error), OW'(vecs[i].err));
      chk($sformatf("v%0d_valid", i), OW'(valid), OW'(!vecs[i].err));
      chk($sformatf("v%0d_res_dims", i), OW'({res_m, res_n}), OW'({vecs[i].rm, vecs[i].rn}));
      chk($sformatf("v%0d_result", i), OW'(matrices_out[HW-1:0]), OW'(vecs[i].c));
      chk($sformatf("v%0d_high_half", i), OW'(matrices_out[OW-1:HW]), '0);
      if (i == 4) chk("v4_layout_byte5", OW'(matrices_out[47:40]), OW'(2));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse_busy_end", i), OW'({done, busy}), '0);
    end

    // start pulsed mid-RUN with different inputs must not disturb the first request
    issue(vecs[0]);
    @(negedge clk);
    op = 2'b01; m = 3'd4; n = 3'd4; matrices_in = {fill(4,4,9), fill(4,4,99)};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("midrun_start_latency", OW'(lat), OW'(6));
    chk("midrun_start_result", OW'(matrices_out[HW-1:0]), OW'(vecs[0].c));
    chk("midrun_start_valid", OW'({valid, error}), OW'(2'b10));

    // start raised during the done cycle is ignored
    op = 2'b00; m = 3'd1; n = 3'd1;
    matrices_in = {vecs[7].b, vecs[7].a};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_cycle_start_busy", OW'(busy), '0);
    chk("done_cycle_start_hold", OW'(matrices_out[HW-1:0]), OW'(vecs[0].c));
    chk("done_cycle_start_valid", OW'(valid), OW'(1));

    // reset mid-RUN clears outputs asynchronously and suppresses done
    issue(vecs[2]);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrun_reset_out", matrices_out, '0);
    chk("midrun_reset_flags", OW'({busy, done, valid, error, res_m, res_n}), '0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) done_seen = 1;
    end
    chk("midrun_reset_no_done", OW'(done_seen), '0);
    @(negedge clk);
    reset = 1'b1;

    issue(vecs[1]);
    wait_done(lat);
    chk("post_reset_latency", OW'(lat), OW'(vecs[1].lat));
    chk("post_reset_result", OW'(matrices_out[HW-1:0]), OW'(vecs[1].c));
    chk("post_reset_flags", OW'({valid, error, res_m, res_n}), OW'({1'b1, 1'b0, 3'd2, 3'd3}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
